// File: rtl/ddbb256_cfg_pkg.sv
// Shared types and helpers for the config-space enumerator: FSM states, config
// register offsets and the address/byte-lane encoders for the 256-bit config bus.
package ddbb256_cfg_pkg;

    typedef enum logic [3:0] {
        StIdle,
        StRdId,
        StWrOnes,
        StRdMask,
        StWrBar,
        StWrIrq,
        StWrCmd,
        StNext,
        StDone
    } cfg_state_e;

    // Absolute byte offsets; bit 5 selects the 32-byte row, bits [4:0] the lane.
    localparam logic [5:0] CFG_OFS_VENDOR = 6'h00;
    localparam logic [5:0] CFG_OFS_CMD    = 6'h04;
    localparam logic [5:0] CFG_OFS_BAR0   = 6'h10;
    localparam logic [5:0] CFG_OFS_IRQ    = 6'h3C;

    localparam int unsigned NUM_BAR = 3;

    function automatic logic [31:0] cfg_adr(input logic [7:0] bus, input logic [4:0] dev,
                                            input logic [2:0] func, input logic [3:0] row);
        return {4'h0, bus, dev, func, 3'd0, row, 5'd0};
    endfunction

    function automatic logic [31:0] lane_sel(input logic [4:0] ofs, input logic [2:0] bytes);
        logic [31:0] m;
        m = (32'd1 << bytes) - 32'd1;
        return m << ofs;
    endfunction

    function automatic logic [5:0] bar_ofs(input logic [1:0] bar);
        return CFG_OFS_BAR0 + {2'b00, bar, 2'b00};
    endfunction

endpackage

// File: rtl/ddbb256_bar_alloc.sv
// Combinational BAR sizing: turns an all-ones readback into a naturally aligned
// base address from the running allocation pointer, with limit/overflow detection.
module ddbb256_bar_alloc (
    input  logic [31:0] readback_i,
    input  logic [31:0] alloc_i,
    input  logic [31:0] limit_i,
    output logic [31:0] bar_val_o,
    output logic [31:0] next_alloc_o,
    output logic        fail_o
);

    logic [31:0] size_mask;
    logic [31:0] size;
    logic [32:0] size_m1;
    logic [32:0] base;
    logic [32:0] last;

    always_comb begin
        size_mask = readback_i & ~32'hF;
        size      = ~size_mask + 32'd1;
        size_m1   = {1'b0, size} - 33'd1;
        // 33-bit so that rounding up past 4 GiB shows up in bit 32 instead of wrapping.
        base      = ({1'b0, alloc_i} + size_m1) & ~size_m1;
        last      = base + size_m1;

        bar_val_o    = '0;
        next_alloc_o = alloc_i;
        fail_o       = 1'b0;
        if (size_mask != '0) begin
            if (last > {1'b0, limit_i}) begin
                fail_o = 1'b1;
            end else begin
                bar_val_o    = base[31:0];
                next_alloc_o = last[31:0] + 32'd1;
            end
        end
    end

endmodule

// File: rtl/ddbb256_cfg_enum.sv
// Config-space enumerator: walks function 0 of each device on one bus, sizes and
// assigns BAR0..BAR2, programs the IRQ line and enables memory decoding.
module ddbb256_cfg_enum
    import ddbb256_cfg_pkg::*;
#(
    parameter int unsigned NUM_DEV   = 8,
    parameter logic [7:0]  CFG_BUS   = 8'd0,
    parameter logic [31:0] MEM_BASE  = 32'h4000_0000,
    parameter logic [31:0] MEM_LIMIT = 32'h7FFF_FFFF,
    parameter int unsigned TIMEOUT   = 16,
    parameter logic [7:0]  IRQ_BASE  = 8'd16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    output logic               busy_o,
    output logic               done_o,
    output logic               err_o,
    output logic [NUM_DEV-1:0] dev_found_o,
    output logic               cs_config_o,
    output logic               cyc_o,
    output logic               stb_o,
    output logic               we_o,
    output logic [31:0]        sel_o,
    output logic [31:0]        adr_o,
    output logic [255:0]       dat_o,
    input  logic               ack_i,
    input  logic [255:0]       dat_i
);

    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    cfg_state_e         state_q;
    logic [4:0]         dev_q;
    logic [1:0]         bar_q;
    logic [31:0]        alloc_q;
    logic [31:0]        bar_val_q;
    logic               dev_fail_q;
    logic [TW-1:0]      tmo_q;
    logic               busy_q;
    logic               done_q;
    logic               err_q;
    logic [NUM_DEV-1:0] found_q;
    logic               cyc_q;
    logic               we_q;
    logic [31:0]        sel_q;
    logic [31:0]        adr_q;
    logic [255:0]       dat_q;

    logic               tmo_hit;
    logic               xfer_end;
    logic [255:0]       resp;
    logic [15:0]        vendor;
    logic [31:0]        bar_rb;
    logic [31:0]        alloc_val;
    logic [31:0]        alloc_next;
    logic               alloc_fail;

    logic               acc_we;
    logic [5:0]         acc_ofs;
    logic [2:0]         acc_len;
    logic [31:0]        acc_val;
    logic [31:0]        acc_adr;
    logic [31:0]        acc_sel;
    logic [255:0]       acc_dat;

    assign tmo_hit  = (tmo_q == TW'(TIMEOUT - 1));
    assign xfer_end = cyc_q && (ack_i || tmo_hit);
    // An abandoned read looks like an empty slot: all ones.
    assign resp     = ack_i ? dat_i : '1;
    assign vendor   = resp[{CFG_OFS_VENDOR, 3'b000} +: 16];
    assign bar_rb   = resp[{bar_ofs(bar_q), 3'b000} +: 32];

    ddbb256_bar_alloc u_bar_alloc (
        .readback_i   (bar_rb),
        .alloc_i      (alloc_q),
        .limit_i      (MEM_LIMIT),
        .bar_val_o    (alloc_val),
        .next_alloc_o (alloc_next),
        .fail_o       (alloc_fail)
    );

    // Access the current state issues; reads always fetch the whole of row 0.
    always_comb begin
        acc_we  = 1'b0;
        acc_ofs = CFG_OFS_VENDOR;
        acc_len = 3'd4;
        acc_val = 32'hFFFF_FFFF;
        case (state_q)
            StWrOnes: begin
                acc_we  = 1'b1;
                acc_ofs = bar_ofs(bar_q);
            end
            StWrBar: begin
                acc_we  = 1'b1;
                acc_ofs = bar_ofs(bar_q);
                acc_val = bar_val_q;
            end
            StWrIrq: begin
                acc_we  = 1'b1;
                acc_ofs = CFG_OFS_IRQ;
                acc_len = 3'd1;
                acc_val = {24'd0, IRQ_BASE + {3'd0, dev_q}};
            end
            StWrCmd: begin
                acc_we  = 1'b1;
                acc_ofs = CFG_OFS_CMD;
                acc_len = 3'd2;
                acc_val = dev_fail_q ? 32'h0000_0004 : 32'h0000_0006;
            end
            default: ;
        endcase
        acc_adr = cfg_adr(CFG_BUS, dev_q, 3'd0, {3'd0, acc_ofs[5]});
        acc_sel = acc_we ? lane_sel(acc_ofs[4:0], acc_len) : '1;
        acc_dat = acc_we ? ({224'd0, acc_val} << {acc_ofs[4:0], 3'b000}) : '0;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= StIdle;
            dev_q      <= '0;
            bar_q      <= '0;
            alloc_q    <= MEM_BASE;
            bar_val_q  <= '0;
            dev_fail_q <= 1'b0;
            tmo_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            found_q    <= '0;
            cyc_q      <= 1'b0;
            we_q       <= 1'b0;
            sel_q      <= '0;
            adr_q      <= '0;
            dat_q      <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        busy_q  <= 1'b1;
                        err_q   <= 1'b0;
                        found_q <= '0;
                        dev_q   <= '0;
                        bar_q   <= '0;
                        alloc_q <= MEM_BASE;
                        state_q <= StRdId;
                    end
                end
                StRdId, StWrOnes, StRdMask, StWrBar, StWrIrq, StWrCmd: begin
                    if (!cyc_q) begin
                        cyc_q <= 1'b1;
                        we_q  <= acc_we;
                        sel_q <= acc_sel;
                        adr_q <= acc_adr;
                        dat_q <= acc_dat;
                    end else if (xfer_end) begin
                        cyc_q <= 1'b0;
                        we_q  <= 1'b0;
                        tmo_q <= '0;
                        case (state_q)
                            StRdId: begin
                                dev_fail_q <= 1'b0;
                                bar_q      <= '0;
                                if (vendor == 16'hFFFF) begin
                                    state_q <= StNext;
                                end else begin
                                    found_q <= found_q | (NUM_DEV'(1) << dev_q);
                                    state_q <= StWrOnes;
                                end
                            end
                            StWrOnes: state_q <= StRdMask;
                            StRdMask: begin
                                bar_val_q <= alloc_val;
                                alloc_q   <= alloc_next;
                                if (alloc_fail) begin
                                    err_q      <= 1'b1;
                                    dev_fail_q <= 1'b1;
                                end
                                state_q <= StWrBar;
                            end
                            StWrBar: begin
                                if (bar_q == 2'(NUM_BAR - 1)) begin
                                    state_q <= StWrIrq;
                                end else begin
                                    bar_q   <= bar_q + 2'd1;
                                    state_q <= StWrOnes;
                                end
                            end
                            StWrIrq: state_q <= StWrCmd;
                            default: state_q <= StNext;
                        endcase
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                StNext: begin
                    if (dev_q == 5'(NUM_DEV - 1)) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= StDone;
                    end else begin
                        dev_q   <= dev_q + 5'd1;
                        bar_q   <= '0;
                        state_q <= StRdId;
                    end
                end
                StDone: state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign err_o       = err_q;
    assign dev_found_o = found_q;
    assign cs_config_o = cyc_q;
    assign cyc_o       = cyc_q;
    assign stb_o       = cyc_q;
    assign we_o        = we_q;
    assign sel_o       = sel_q;
    assign adr_o       = adr_q;
    assign dat_o       = dat_q;

endmodule

// File: tb/tb_ddbb256_cfg_enum.sv
// Bench for the config enumerator: behavioural device models answer the bus, a
// reference model queues the expected access stream, and a monitor checks it.
module tb_ddbb256_cfg_enum;

    localparam int unsigned NUM_DEV   = 8;
    localparam logic [7:0]  CFG_BUS   = 8'h03;
    localparam logic [31:0] MEM_BASE  = 32'h4000_0000;
    localparam logic [31:0] MEM_LIMIT = 32'h7FFF_FFFF;
    localparam int unsigned TIMEOUT   = 16;
    localparam logic [7:0]  IRQ_BASE  = 8'd16;

    logic               clk_i = 1'b0;
    logic               rst_i = 1'b0;
    logic               start_i = 1'b0;
    logic               ack_i = 1'b0;
    logic [255:0]       dat_i = '0;
    logic               busy_o, done_o, err_o, cs_config_o, cyc_o, stb_o, we_o;
    logic [NUM_DEV-1:0] dev_found_o;
    logic [31:0]        sel_o, adr_o;
    logic [255:0]       dat_o;

    ddbb256_cfg_enum #(
        .NUM_DEV   (NUM_DEV),
        .CFG_BUS   (CFG_BUS),
        .MEM_BASE  (MEM_BASE),
        .MEM_LIMIT (MEM_LIMIT),
        .TIMEOUT   (TIMEOUT),
        .IRQ_BASE  (IRQ_BASE)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .start_i     (start_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .err_o       (err_o),
        .dev_found_o (dev_found_o),
        .cs_config_o (cs_config_o),
        .cyc_o       (cyc_o),
        .stb_o       (stb_o),
        .we_o        (we_o),
        .sel_o       (sel_o),
        .adr_o       (adr_o),
        .dat_o       (dat_o),
        .ack_i       (ack_i),
        .dat_i       (dat_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic         we;
        logic [31:0]  adr;
        logic [31:0]  sel;
        logic [255:0] dat;
        bit           tmo;
    } acc_t;

    acc_t exp_q[$];

    int errors = 0;
    int checks = 0;
    int done_cnt = 0;

    // Device population: 0 = no responder, 1 = answers with vendor FFFF, 2 = real device.
    int           kind [NUM_DEV];
    logic [31:0]  bmask [NUM_DEV][3];
    logic [255:0] row0 [NUM_DEV];
    logic [255:0] row1 [NUM_DEV];

    logic [31:0]        exp_bar [NUM_DEV][3];
    logic [15:0]        exp_cmd [NUM_DEV];
    logic [7:0]         exp_irq [NUM_DEV];
    logic [NUM_DEV-1:0] exp_found;
    bit                 exp_err;

    logic [31:0] mask_tab [6] = '{32'h0, 32'hFFFF_FFF0, 32'hFFFF_F000, 32'hFFF0_0000,
                                  32'hFF00_0000, 32'hF000_0000};

    task automatic chk(input string name, input bit ok, input string detail);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: %s", name, detail);
        end
    endtask

    function automatic logic [255:0] bytemask(input logic [31:0] sel);
        logic [255:0] m;
        m = '0;
        for (int i = 0; i < 32; i++) if (sel[i]) m[8*i +: 8] = 8'hFF;
        return m;
    endfunction

    function automatic logic [31:0] adr_of(input int d, input int row);
        return {4'h0, CFG_BUS, 5'(d), 3'd0, 3'd0, 4'(row), 5'd0};
    endfunction

    function automatic void push_rd(input int d, input bit tmo);
        acc_t a;
        a.we = 1'b0; a.adr = adr_of(d, 0); a.sel = '0; a.dat = '0; a.tmo = tmo;
        exp_q.push_back(a);
    endfunction

    function automatic void push_wr(input int d, input int ofs, input int nbytes,
                                    input logic [31:0] val);
        acc_t a;
        a.we = 1'b1; a.adr = adr_of(d, ofs / 32); a.sel = '0; a.dat = '0; a.tmo = 1'b0;
        for (int i = 0; i < nbytes; i++) begin
            a.sel[ofs % 32 + i] = 1'b1;
            a.dat[8*(ofs % 32 + i) +: 8] = val[8*i +: 8];
        end
        exp_q.push_back(a);
    endfunction

    // Reference: PCI-style sizing with natural alignment, computed by division.
    function automatic void build_expect();
        longint unsigned alloc, size, base, m;
        bit dfail;
        exp_q.delete();
        exp_found = '0;
        exp_err   = 1'b0;
        alloc     = MEM_BASE;
        for (int d = 0; d < NUM_DEV; d++) begin
            exp_cmd[d] = '0;
            exp_irq[d] = '0;
            for (int b = 0; b < 3; b++) exp_bar[d][b] = '0;
            push_rd(d, kind[d] == 0);
            if (kind[d] == 2) begin
                exp_found[d] = 1'b1;
                dfail = 1'b0;
                for (int b = 0; b < 3; b++) begin
                    push_wr(d, 16 + 4*b, 4, 32'hFFFF_FFFF);
                    push_rd(d, 1'b0);
                    m = bmask[d][b];
                    if (m != 0) begin
                        size = 64'h1_0000_0000 - m;
                        base = ((alloc + size - 1) / size) * size;
                        if (base + size - 1 > MEM_LIMIT) begin
                            dfail = 1'b1;
                            exp_err = 1'b1;
                        end else begin
                            exp_bar[d][b] = base[31:0];
                            alloc = base + size;
                        end
                    end
                    push_wr(d, 16 + 4*b, 4, exp_bar[d][b]);
                end
                exp_irq[d] = 8'((IRQ_BASE + d) % 256);
                push_wr(d, 60, 1, {24'd0, exp_irq[d]});
                exp_cmd[d] = dfail ? 16'h0004 : 16'h0006;
                push_wr(d, 4, 2, {16'd0, exp_cmd[d]});
            end
        end
    endfunction

    function automatic void init_devices();
        for (int d = 0; d < NUM_DEV; d++) begin
            row0[d] = '0;
            row1[d] = '0;
            if (kind[d] == 1) row0[d][15:0] = 16'hFFFF;
            if (kind[d] == 2) begin
                row0[d][15:0]  = 16'h10E0 + 16'(d);
                row0[d][31:16] = 16'hA000 + 16'(d);
            end
        end
    endfunction

    function automatic void clear_cfg();
        for (int d = 0; d < NUM_DEV; d++) begin
            kind[d] = 0;
            for (int b = 0; b < 3; b++) bmask[d][b] = '0;
        end
    endfunction

    // Responder: acks after 0..3 idle cycles, applies writes with BAR masking.
    int rsp_wait = 0;
    int rsp_target = 0;
    initial begin
        forever begin
            @(negedge clk_i);
            if (!rst_i) begin
                ack_i = 1'b0;
                rsp_wait = 0;
            end else if (ack_i) begin
                ack_i = 1'b0;
            end else if (cyc_o && stb_o) begin
                int d;
                d = int'(adr_o[19:15]);
                if (d < NUM_DEV && kind[d] != 0 && adr_o[27:20] == CFG_BUS) begin
                    if (rsp_wait >= rsp_target) begin
                        ack_i = 1'b1;
                        rsp_wait = 0;
                        rsp_target = $urandom_range(0, 3);
                        if (we_o) begin
                            if (adr_o[8:5] == 4'd0) begin
                                row0[d] = (row0[d] & ~bytemask(sel_o)) | (dat_o & bytemask(sel_o));
                                for (int b = 0; b < 3; b++)
                                    row0[d][8*(16+4*b) +: 32] = row0[d][8*(16+4*b) +: 32] & bmask[d][b];
                            end else begin
                                row1[d] = (row1[d] & ~bytemask(sel_o)) | (dat_o & bytemask(sel_o));
                            end
                        end else begin
                            dat_i = (adr_o[8:5] == 4'd0) ? row0[d] : row1[d];
                        end
                    end else begin
                        rsp_wait++;
                    end
                end
            end
        end
    end

    // Monitor: one scoreboard pop per completed bus access.
    acc_t mon_cur, mon_exp;
    bit   mon_active = 1'b0;
    bit   mon_stable = 1'b0;
    int   mon_dur = 0;
    initial begin
        forever begin
            @(negedge clk_i);
            if (done_o) done_cnt++;
            if (!rst_i) begin
                mon_active = 1'b0;
            end else if (cyc_o) begin
                if (!mon_active) begin
                    mon_active  = 1'b1;
                    mon_cur.we  = we_o;
                    mon_cur.adr = adr_o;
                    mon_cur.sel = sel_o;
                    mon_cur.dat = dat_o;
                    mon_dur     = 0;
                    mon_stable  = stb_o && cs_config_o;
                end else if (we_o !== mon_cur.we || adr_o !== mon_cur.adr ||
                             sel_o !== mon_cur.sel || dat_o !== mon_cur.dat ||
                             !stb_o || !cs_config_o) begin
                    mon_stable = 1'b0;
                end
                mon_dur++;
            end else if (mon_active) begin
                mon_active = 1'b0;
                if (exp_q.size() == 0) begin
                    chk("unexpected_access", 1'b0,
                        $sformatf("got we=%0b adr=%h, want no access", mon_cur.we, mon_cur.adr));
                end else begin
                    mon_exp = exp_q.pop_front();
                    chk("acc_we", mon_cur.we == mon_exp.we,
                        $sformatf("adr=%h got we=%0b want %0b", mon_cur.adr, mon_cur.we, mon_exp.we));
                    chk("acc_adr", mon_cur.adr == mon_exp.adr,
                        $sformatf("got %h want %h", mon_cur.adr, mon_exp.adr));
                    if (mon_exp.we) begin
                        chk("acc_sel", mon_cur.sel == mon_exp.sel,
                            $sformatf("got %h want %h", mon_cur.sel, mon_exp.sel));
                        chk("acc_dat", (mon_cur.dat & bytemask(mon_exp.sel)) == mon_exp.dat,
                            $sformatf("got %h want %h", mon_cur.dat & bytemask(mon_exp.sel),
                                      mon_exp.dat));
                    end
                    if (mon_exp.tmo)
                        chk("acc_timeout_len", mon_dur == TIMEOUT,
                            $sformatf("got %0d cycles want %0d", mon_dur, TIMEOUT));
                    else
                        chk("acc_ack_len", mon_dur <= 4,
                            $sformatf("got %0d cycles want <=4", mon_dur));
                    chk("acc_stable", mon_stable,
                        $sformatf("adr=%h got unstable/stb!=cyc, want stable", mon_cur.adr));
                end
            end
        end
    end

    task automatic check_regs();
        for (int d = 0; d < NUM_DEV; d++) begin
            for (int b = 0; b < 3; b++)
                chk($sformatf("bar_d%0d_b%0d", d, b), row0[d][8*(16+4*b) +: 32] == exp_bar[d][b],
                    $sformatf("got %h want %h", row0[d][8*(16+4*b) +: 32], exp_bar[d][b]));
            chk($sformatf("cmd_d%0d", d), row0[d][32 +: 16] == exp_cmd[d],
                $sformatf("got %h want %h", row0[d][32 +: 16], exp_cmd[d]));
            chk($sformatf("irq_d%0d", d), row1[d][224 +: 8] == exp_irq[d],
                $sformatf("got %h want %h", row1[d][224 +: 8], exp_irq[d]));
        end
    endtask

    task automatic run_scan(input string tag, input bit poke_busy);
        bit seen;
        init_devices();
        build_expect();
        done_cnt = 0;
        @(negedge clk_i);
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        chk({tag, "_busy_after_start"}, busy_o == 1'b1, $sformatf("got %0b want 1", busy_o));
        seen = 1'b0;
        for (int c = 0; c < 20000; c++) begin
            @(negedge clk_i);
            if (poke_busy && c == 40) begin
                chk({tag, "_busy_at_poke"}, busy_o == 1'b1, $sformatf("got %0b want 1", busy_o));
                start_i = 1'b1;
            end else if (poke_busy && c == 41) begin
                start_i = 1'b0;
            end
            if (done_o) begin
                seen = 1'b1;
                break;
            end
        end
        start_i = 1'b0;
        chk({tag, "_done_seen"}, seen, "got no done_o within budget, want done_o");
        repeat (4) @(negedge clk_i);
        chk({tag, "_done_count"}, done_cnt == 1, $sformatf("got %0d want 1", done_cnt));
        chk({tag, "_busy_end"}, busy_o == 1'b0, $sformatf("got %0b want 0", busy_o));
        chk({tag, "_all_accesses"}, exp_q.size() == 0,
            $sformatf("got %0d outstanding want 0", exp_q.size()));
        chk({tag, "_dev_found"}, dev_found_o == exp_found,
            $sformatf("got %h want %h", dev_found_o, exp_found));
        chk({tag, "_err"}, err_o == exp_err, $sformatf("got %0b want %0b", err_o, exp_err));
        check_regs();
    endtask

    task automatic reset_mid_write();
        bit hit;
        clear_cfg();
        kind[0] = 2;
        bmask[0][0] = 32'hFFF0_0000;
        init_devices();
        build_expect();
        @(negedge clk_i);
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk_i);
            #2;
            if (cyc_o && we_o) begin
                hit = 1'b1;
                break;
            end
        end
        chk("rst_reached_wr_ones", hit, "got no write cycle, want WR_ONES write");
        rst_i = 1'b0;
        #1;
        chk("rst_cyc_drop", cyc_o == 1'b0, $sformatf("got %0b want 0", cyc_o));
        chk("rst_stb_drop", stb_o == 1'b0, $sformatf("got %0b want 0", stb_o));
        chk("rst_busy_drop", busy_o == 1'b0, $sformatf("got %0b want 0", busy_o));
        repeat (2) @(negedge clk_i);
        rst_i = 1'b1;
        exp_q.delete();
    endtask

    initial begin
        clear_cfg();
        init_devices();
        repeat (3) @(negedge clk_i);
        chk("reset_busy", busy_o == 1'b0, $sformatf("got %0b want 0", busy_o));
        chk("reset_done", done_o == 1'b0, $sformatf("got %0b want 0", done_o));
        chk("reset_err", err_o == 1'b0, $sformatf("got %0b want 0", err_o));
        chk("reset_found", dev_found_o == '0, $sformatf("got %h want 0", dev_found_o));
        chk("reset_cyc", (cyc_o | stb_o | we_o | cs_config_o) == 1'b0,
            $sformatf("got cyc=%0b stb=%0b we=%0b cs=%0b want 0", cyc_o, stb_o, we_o, cs_config_o));
        rst_i = 1'b1;
        repeat (2) @(negedge clk_i);

        // Single device, one 1 MiB BAR; a start pulse mid-scan must be ignored.
        clear_cfg();
        kind[0] = 2;
        bmask[0][0] = 32'hFFF0_0000;
        run_scan("scan_a", 1'b1);
        chk("a_bar0", row0[0][128 +: 32] == 32'h4000_0000, $sformatf("got %h", row0[0][128 +: 32]));
        chk("a_irq", row1[0][224 +: 8] == 8'd16, $sformatf("got %h want 10", row1[0][224 +: 8]));
        chk("a_cmd", row0[0][32 +: 16] == 16'h0006, $sformatf("got %h want 0006", row0[0][32 +: 16]));
        chk("a_found", dev_found_o == 8'h01, $sformatf("got %h want 01", dev_found_o));

        // Alignment: 4 KiB then 1 MiB rounds up; dev 5 answers but is empty.
        clear_cfg();
        kind[2] = 2; bmask[2][0] = 32'hFFFF_F000;
        kind[3] = 2; bmask[3][0] = 32'hFFF0_0000;
        kind[5] = 1;
        run_scan("scan_b", 1'b0);
        chk("b_dev2_bar0", row0[2][128 +: 32] == 32'h4000_0000, $sformatf("got %h", row0[2][128 +: 32]));
        chk("b_dev3_bar0", row0[3][128 +: 32] == 32'h4010_0000, $sformatf("got %h", row0[3][128 +: 32]));

        // Nobody home: every ID read times out, no writes.
        clear_cfg();
        run_scan("scan_c", 1'b0);
        chk("c_found", dev_found_o == 8'h00, $sformatf("got %h want 00", dev_found_o));

        // Exhaustion: 1 GiB fills the window, everything after fails.
        clear_cfg();
        kind[0] = 2; bmask[0][0] = 32'hC000_0000; bmask[0][1] = 32'hFF00_0000;
        kind[1] = 2; bmask[1][0] = 32'hFFFF_F000;
        run_scan("scan_d", 1'b0);
        chk("d_err", err_o == 1'b1, $sformatf("got %0b want 1", err_o));
        chk("d_bar0", row0[0][128 +: 32] == 32'h4000_0000, $sformatf("got %h", row0[0][128 +: 32]));
        chk("d_bar1", row0[0][160 +: 32] == 32'h0, $sformatf("got %h want 0", row0[0][160 +: 32]));
        chk("d_cmd", row0[0][32 +: 16] == 16'h0004, $sformatf("got %h want 0004", row0[0][32 +: 16]));

        reset_mid_write();
        clear_cfg();
        kind[0] = 2;
        bmask[0][0] = 32'hFFF0_0000;
        run_scan("scan_after_rst", 1'b0);

        for (int s = 0; s < 6; s++) begin
            clear_cfg();
            for (int d = 0; d < NUM_DEV; d++) begin
                int k;
                k = $urandom_range(0, 9);
                kind[d] = (k < 6) ? 2 : ((k < 8) ? 0 : 1);
                for (int b = 0; b < 3; b++) bmask[d][b] = mask_tab[$urandom_range(0, 5)];
            end
            run_scan($sformatf("rand%0d", s), 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
